// File: rtl/cvt_int_fp_pkg.sv
// Shared constants, types and the rounding helper for the integer to
// floating-point converter.
package cvt_int_fp_pkg;

    // Kept significand widths, hidden/explicit leading bit included
    localparam int EXT_PREC = 64;
    localparam int DBL_PREC = 53;
    localparam int SNG_PREC = 24;

    // Exponent bias of each internal result format
    localparam logic [15:0] EXT_BIAS = 16'h7fff;
    localparam logic [11:0] DBL_BIAS = 12'h7ff;
    localparam logic [8:0]  SNG_BIAS = 9'hff;

    typedef enum logic [1:0] {
        FMT_EXT = 2'd0,
        FMT_DBL = 2'd1,
        FMT_SNG = 2'd2
    } fmt_t;

    typedef struct packed {
        logic [63:0] mant;
        logic        carry;
        logic        inexact;
    } rnd_t;

    // Round a normalized 65-bit magnitude (leading one in bit 64) to prec
    // bits, nearest-even. Every discarded bit below the kept LSB lands in
    // rem: rem[64] is the guard bit, the rest form round and sticky.
    function automatic rnd_t round_rne(input logic [64:0] norm, input int prec);
        rnd_t        r;
        logic [64:0] kept;
        logic [64:0] rem;
        logic [64:0] sum;
        logic        up;
        kept      = norm >> (65 - prec);
        rem       = norm << prec;
        up        = rem[64] & ((|rem[63:0]) | kept[0]);
        sum       = kept + {64'd0, up};
        r.carry   = |(sum >> prec);
        r.mant    = r.carry ? (64'd1 << (prec - 1)) : sum[63:0];
        r.inexact = |rem;
        return r;
    endfunction

endpackage

// File: rtl/lead_one_det64.sv
// Leading-one detector over a 65-bit magnitude: returns the bit index of
// the most significant set bit and flags an all-zero input.
module lead_one_det64 (
    input  logic [64:0] value,
    output logic [6:0]  index,
    output logic        zero
);

    // Scan upward so the highest set bit wins
    always_comb begin
        index = 7'd0;
        for (int i = 0; i < 65; i++) begin
            if (value[i]) index = 7'(i);
        end
        zero = ~|value;
    end

endmodule

// File: rtl/cvt_int_fp.sv
// Three-stage integer to floating-point converter: magnitude, normalize,
// round and pack. clkEn freezes the whole pipeline, valid bits included.
module cvt_int_fp
    import cvt_int_fp_pkg::*;
#(
    parameter logic [15:0] BIAS = EXT_BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clkEn,
    input  logic        en,
    input  logic [63:0] A,
    input  logic        isSigned,
    input  logic        is32b,
    input  logic        isEXT,
    input  logic        isDBL,
    input  logic        isSNG,
    output logic [81:0] res,
    output logic        res_vld,
    output logic        inexact
);

    logic [63:0] ext_op;
    logic        op_sign;
    logic [64:0] op_mag;
    fmt_t        op_fmt;

    logic        s1_vld;
    logic        s1_sign;
    logic [64:0] s1_mag;
    fmt_t        s1_fmt;

    logic [6:0]  lead_idx;
    logic        lead_zero;

    logic        s2_vld;
    logic        s2_sign;
    logic        s2_zero;
    logic [6:0]  s2_p;
    logic [64:0] s2_norm;
    fmt_t        s2_fmt;

    rnd_t        rnd;
    logic [15:0] e_ext;
    logic [11:0] e_dbl;
    logic [8:0]  e_sng;
    logic [81:0] packed_res;
    logic        packed_inex;

    // Widen to 64 bits, then take a 65-bit magnitude so -2^63 stays exact
    always_comb begin
        if (is32b) begin
            ext_op = isSigned ? {{32{A[31]}}, A[31:0]} : {32'd0, A[31:0]};
        end else begin
            ext_op = A;
        end
        op_sign = isSigned & ext_op[63];
        op_mag  = op_sign ? (65'd0 - {1'b1, ext_op}) : {1'b0, ext_op};
        if (isEXT)      op_fmt = FMT_EXT;
        else if (isDBL) op_fmt = FMT_DBL;
        else            op_fmt = FMT_SNG;
    end

    // Stage 1 register: sign, magnitude and controls
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_mag  <= '0;
            s1_fmt  <= FMT_EXT;
        end else if (clkEn) begin
            s1_vld  <= en;
            s1_sign <= op_sign;
            s1_mag  <= op_mag;
            s1_fmt  <= op_fmt;
        end
    end

    lead_one_det64 u_lod (
        .value (s1_mag),
        .index (lead_idx),
        .zero  (lead_zero)
    );

    // Stage 2 register: leading-one index and left-normalized magnitude
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_p    <= '0;
            s2_norm <= '0;
            s2_fmt  <= FMT_EXT;
        end else if (clkEn) begin
            s2_vld  <= s1_vld;
            s2_sign <= s1_sign;
            s2_zero <= lead_zero;
            s2_p    <= lead_idx;
            s2_norm <= s1_mag << (7'd64 - lead_idx);
            s2_fmt  <= s1_fmt;
        end
    end

    // Round at the target precision, then pack sign/exponent/fraction
    always_comb begin
        unique case (s2_fmt)
            FMT_EXT: rnd = round_rne(s2_norm, EXT_PREC);
            FMT_DBL: rnd = round_rne(s2_norm, DBL_PREC);
            default: rnd = round_rne(s2_norm, SNG_PREC);
        endcase
        e_ext = BIAS + {9'd0, s2_p} + {15'd0, rnd.carry};
        e_dbl = DBL_BIAS + {5'd0, s2_p} + {11'd0, rnd.carry};
        e_sng = SNG_BIAS + {2'd0, s2_p} + {8'd0, rnd.carry};
        packed_res  = '0;
        packed_inex = rnd.inexact;
        unique case (s2_fmt)
            FMT_EXT: begin
                packed_res[81]    = e_ext[15];
                packed_res[80]    = s2_sign;
                packed_res[79:65] = e_ext[14:0];
                packed_res[64:33] = rnd.mant[63:32];
                packed_res[31:0]  = rnd.mant[31:0];
            end
            FMT_DBL: begin
                packed_res[81]    = e_dbl[11];
                packed_res[64]    = s2_sign;
                packed_res[63:53] = e_dbl[10:0];
                packed_res[52:33] = rnd.mant[51:32];
                packed_res[31:0]  = rnd.mant[31:0];
            end
            default: begin
                packed_res[32]    = e_sng[8];
                packed_res[31]    = s2_sign;
                packed_res[30:23] = e_sng[7:0];
                packed_res[22:0]  = rnd.mant[22:0];
            end
        endcase
        if (s2_zero) begin
            packed_res  = '0;
            packed_inex = 1'b0;
        end
    end

    // Stage 3 register: outputs forced to zero whenever not valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_vld <= 1'b0;
            res     <= '0;
            inexact <= 1'b0;
        end else if (clkEn) begin
            res_vld <= s2_vld;
            res     <= s2_vld ? packed_res : '0;
            inexact <= s2_vld & packed_inex;
        end
    end

endmodule

// File: tb/tb_cvt_int_fp.sv
// Testbench for cvt_int_fp: vector table through a latency-tracking
// scoreboard, plus stall and reset-in-flight sequences.
module tb_cvt_int_fp;

    logic        clk = 1'b0;
    logic        rst;
    logic        clkEn;
    logic        en;
    logic [63:0] A;
    logic        isSigned;
    logic        is32b;
    logic        isEXT;
    logic        isDBL;
    logic        isSNG;
    logic [81:0] res;
    logic        res_vld;
    logic        inexact;

    typedef struct {
        logic [63:0] a;
        logic        sgn;
        logic        w32;
        logic [1:0]  fmt;
        logic [81:0] res;
        logic        inex;
    } vec_t;

    typedef struct {
        logic [81:0] res;
        logic        inex;
        int          due;
        int          id;
    } sb_t;

    vec_t vecs[18];
    sb_t  sb[$];
    int   adv_count = 0;
    int   tests = 0;
    int   fails = 0;

    logic        prev_vld = 1'b0;
    logic [81:0] prev_res = '0;
    logic        prev_inex = 1'b0;

    cvt_int_fp dut (
        .clk      (clk),
        .rst      (rst),
        .clkEn    (clkEn),
        .en       (en),
        .A        (A),
        .isSigned (isSigned),
        .is32b    (is32b),
        .isEXT    (isEXT),
        .isDBL    (isDBL),
        .isSNG    (isSNG),
        .res      (res),
        .res_vld  (res_vld),
        .inexact  (inexact)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [81:0] pk_ext(logic s, logic [15:0] e, logic [63:0] m);
        logic [81:0] r;
        r = '0;
        r[81] = e[15];
        r[80] = s;
        r[79:65] = e[14:0];
        r[64:33] = m[63:32];
        r[31:0] = m[31:0];
        return r;
    endfunction

    function automatic logic [81:0] pk_dbl(logic s, logic [11:0] e, logic [51:0] f);
        logic [81:0] r;
        r = '0;
        r[81] = e[11];
        r[64] = s;
        r[63:53] = e[10:0];
        r[52:33] = f[51:32];
        r[31:0] = f[31:0];
        return r;
    endfunction

    function automatic logic [81:0] pk_sng(logic s, logic [8:0] e, logic [22:0] f);
        logic [81:0] r;
        r = '0;
        r[32] = e[8];
        r[31] = s;
        r[30:23] = e[7:0];
        r[22:0] = f;
        return r;
    endfunction

    task automatic check_output(input string name, input logic [81:0] actual,
                                input logic [81:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one operand on the next edge and record what it must produce
    task automatic apply_stimulus(input int idx);
        A        = vecs[idx].a;
        isSigned = vecs[idx].sgn;
        is32b    = vecs[idx].w32;
        isEXT    = (vecs[idx].fmt == 2'd0);
        isDBL    = (vecs[idx].fmt == 2'd1);
        isSNG    = (vecs[idx].fmt == 2'd2);
        en       = 1'b1;
        clkEn    = 1'b1;
        if (rst) sb.push_back('{res: vecs[idx].res, inex: vecs[idx].inex,
                                due: adv_count + 3, id: idx});
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ce, input logic junk_en);
        en    = junk_en;
        clkEn = ce;
        A     = 64'h0000_0000_0000_0007;
        repeat (n) @(negedge clk);
    endtask

    // Output monitor: pops the scoreboard on advancing edges, checks
    // reset clearing and holding during stalls
    always @(posedge clk) begin
        logic adv_s;
        logic rst_s;
        sb_t  e;
        adv_s = clkEn & rst;
        rst_s = ~rst;
        #1;
        if (rst_s) begin
            sb.delete();
            check_output("rst_vld", {81'd0, res_vld}, 82'd0);
            check_output("rst_res", res, 82'd0);
            check_output("rst_inexact", {81'd0, inexact}, 82'd0);
        end else if (adv_s) begin
            adv_count++;
            if (res_vld) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_vld", {81'd0, res_vld}, 82'd0);
                end else begin
                    e = sb.pop_front();
                    check_output($sformatf("latency_v%0d", e.id),
                                 82'(adv_count), 82'(e.due));
                    check_output($sformatf("res_v%0d", e.id), res, e.res);
                    check_output($sformatf("inexact_v%0d", e.id),
                                 {81'd0, inexact}, {81'd0, e.inex});
                end
            end else begin
                if (sb.size() != 0 && sb[0].due <= adv_count) begin
                    e = sb.pop_front();
                    check_output($sformatf("missing_v%0d", e.id), {81'd0, res_vld}, 82'd1);
                end
                check_output("idle_res", {res, inexact} >> 1 | 82'(inexact), 82'd0);
            end
        end else begin
            check_output("hold_vld", {81'd0, res_vld}, {81'd0, prev_vld});
            check_output("hold_res", res, prev_res);
            check_output("hold_inexact", {81'd0, inexact}, {81'd0, prev_inex});
        end
        prev_vld  = res_vld;
        prev_res  = res;
        prev_inex = inexact;
    end

    // Run-time guard so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0]  = '{64'd1, 1'b1, 1'b0, 2'd1, pk_dbl(1'b0, 12'h7ff, 52'd0), 1'b0};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2'd2, pk_sng(1'b1, 9'h0ff, 23'd0), 1'b0};
        vecs[2]  = '{64'h0020_0000_0000_0001, 1'b0, 1'b0, 2'd1, pk_dbl(1'b0, 12'h834, 52'd0), 1'b1};
        vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 2'd2, pk_sng(1'b0, 9'h13f, 23'd0), 1'b1};
        vecs[4]  = '{64'd0, 1'b1, 1'b0, 2'd0, 82'd0, 1'b0};
        vecs[5]  = '{64'd0, 1'b0, 1'b0, 2'd1, 82'd0, 1'b0};
        vecs[6]  = '{64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1, 2'd2, 82'd0, 1'b0};
        vecs[7]  = '{64'h8000_0000_0000_0000, 1'b1, 1'b0, 2'd0,
                     pk_ext(1'b1, 16'h803e, 64'h8000_0000_0000_0000), 1'b0};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 2'd0,
                     pk_ext(1'b0, 16'h803e, 64'hFFFF_FFFF_FFFF_FFFF), 1'b0};
        vecs[9]  = '{64'hDEAD_BEEF_FFFF_FFFE, 1'b1, 1'b1, 2'd2, pk_sng(1'b1, 9'h100, 23'd0), 1'b0};
        vecs[10] = '{64'h1234_5678_8000_0000, 1'b0, 1'b1, 2'd1, pk_dbl(1'b0, 12'h81e, 52'd0), 1'b0};
        vecs[11] = '{64'h0000_0000_0100_0001, 1'b0, 1'b0, 2'd2, pk_sng(1'b0, 9'h117, 23'd0), 1'b1};
        vecs[12] = '{64'h0000_0000_0100_0003, 1'b0, 1'b0, 2'd2, pk_sng(1'b0, 9'h117, 23'd2), 1'b1};
        vecs[13] = '{64'h0020_0000_0000_0003, 1'b0, 1'b0, 2'd1, pk_dbl(1'b0, 12'h834, 52'd2), 1'b1};
        vecs[14] = '{64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0, 2'd1,
                     pk_dbl(1'b1, 12'h800, 52'h8_0000_0000_0000), 1'b0};
        vecs[15] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2'd2, pk_sng(1'b0, 9'h13e, 23'd0), 1'b1};
        vecs[16] = '{64'd5, 1'b0, 1'b0, 2'd0,
                     pk_ext(1'b0, 16'h8001, 64'hA000_0000_0000_0000), 1'b0};
        vecs[17] = '{64'h0000_0000_8000_0000, 1'b1, 1'b1, 2'd0,
                     pk_ext(1'b1, 16'h801e, 64'h8000_0000_0000_0000), 1'b0};

        rst = 1'b0; clkEn = 1'b0; en = 1'b0; A = '0;
        isSigned = 1'b0; is32b = 1'b0; isEXT = 1'b0; isDBL = 1'b1; isSNG = 1'b0;
        repeat (2) @(negedge clk);
        // Reset must win over an advancing cycle with a valid operand
        clkEn = 1'b1; en = 1'b1; A = 64'd9;
        @(negedge clk);
        rst = 1'b1;
        idle(2, 1'b1, 1'b0);

        // Back-to-back table vectors
        for (int i = 0; i < 18; i++) apply_stimulus(i);
        idle(5, 1'b1, 1'b0);

        // Two-cycle stall mid-stream with a junk operand presented
        apply_stimulus(1);
        apply_stimulus(2);
        apply_stimulus(3);
        idle(2, 1'b0, 1'b1);
        apply_stimulus(12);
        apply_stimulus(14);
        idle(6, 1'b1, 1'b0);

        // Reset while two operands are in flight: neither may emerge
        apply_stimulus(0);
        apply_stimulus(9);
        rst = 1'b0; en = 1'b0; clkEn = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(6, 1'b1, 1'b0);

        // First operand after reset release keeps the normal latency
        apply_stimulus(16);
        idle(6, 1'b1, 1'b0);

        check_output("scoreboard_drained", 82'(sb.size()), 82'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cvt_int_fp.md
CVT_INT_FP -- requirements
Module: cvt_int_fp

Interface
REQ-001 SHALL have parameter BIAS, default 16'h7fff, meaning the internal 16-bit exponent bias.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port clkEn, input, 1 bit: pipeline advance enable; when low, every stage holds.
REQ-005 SHALL have port en, input, 1 bit: input operand valid, sampled only when clkEn=1.
REQ-006 SHALL have port A, input, 64 bits: integer operand.
REQ-007 SHALL have port isSigned, input, 1 bit: 1 = two's-complement operand; 0 = unsigned operand.
REQ-008 SHALL have port is32b, input, 1 bit: operand is A[31:0], with bit 31 as sign when isSigned=1.
REQ-009 SHALL have ports isEXT, isDBL and isSNG, input, 1 bit each: target format, exactly one high when en=1.
REQ-010 SHALL have port res, output, 82 bits: packed floating-point result.
REQ-011 SHALL have port res_vld, output, 1 bit: res is valid.
REQ-012 SHALL have port inexact, output, 1 bit: rounding discarded nonzero bits; qualified by res_vld.

Function
REQ-013 Latency SHALL be 3 advancing cycles (clkEn=1); cycles with clkEn=0 SHALL not count, and all stage registers, including valid bits, SHALL hold.
REQ-014 The pipeline SHALL accept one operand per advancing cycle, with no backpressure beyond clkEn.
REQ-015 Stage 1 SHALL sign-extend or zero-extend the operand to 64 bits and take its magnitude.
- The magnitude SHALL be 65 bits so that -2^63 is exact.
- Stage 1 SHALL register the sign, the magnitude and the format/valid controls.
REQ-016 Stage 2 SHALL compute p, the index of the leading one (0..64), and left-normalize the magnitude so that the leading one is in the MSB.
REQ-017 Stage 3 SHALL round to nearest, ties to even, using guard, round and sticky bits at the target precision.
- EXT keeps 64 bits (explicit J bit); EXT SHALL round only for the 65-bit -2^63 case, which is exact.
- DBL keeps 53 bits; SNG keeps 24 bits.
- A mantissa carry-out SHALL increment the exponent and reset the mantissa to 1.0.
REQ-018 Exponent SHALL be computed as follows.
- EXT: E = BIAS + p, 16 bits.
- DBL: E = 12'h7ff + p.
- SNG: E = 9'hff + p.
- The exponent SHALL never overflow.
REQ-019 EXT packing SHALL be: res[81] = E[15]; res[80] = sign; res[79:65] = E[14:0]; res[64:33] = mant[63:32]; res[32] = 0; res[31:0] = mant[31:0].
REQ-020 DBL packing SHALL be: res[81] = E[11]; res[64] = sign; res[63:53] = E[10:0]; res[52:33] = frac[51:32]; res[31:0] = frac[31:0]; all other bits 0.
REQ-021 SNG packing SHALL be: res[32] = E[8]; res[31] = sign; res[30:23] = E[7:0]; res[22:0] = frac; all other bits 0.
REQ-022 A zero operand SHALL produce res = 0 (+0) with inexact = 0, in every format.
REQ-023 When res_vld = 0, res and inexact SHALL be 0.
REQ-024 Simultaneous rst low and clkEn high SHALL give reset priority.

Reset
REQ-025 On rst = 0 at a clock edge, all stage valid bits, res_vld, res and inexact SHALL clear to 0, irrespective of clkEn.
REQ-026 Operands in flight during reset SHALL be discarded and never emitted.
REQ-027 The first valid result after reset release SHALL be emitted 3 advancing cycles after the first accepted en.

Structure
REQ-028 BIAS and the per-format constants (precisions 64/53/24 and bias values 16'h7fff/12'h7ff/9'hff) SHALL live in the shared math package.
REQ-029 Leading-one detection SHALL be one sub-module, lead_one_det64, with 65-bit input and 7-bit index plus zero flag outputs.
- Normalize, round and pack logic SHALL stay in cvt_int_fp.

Verification
REQ-030 Converting A = 1, isSigned = 1, DBL SHALL give, 3 cycles later: res[81] = 0, res[63:53] = 11'h7ff, all else 0, inexact = 0.
REQ-031 Converting A = 64'hFFFF_FFFF_FFFF_FFFF, isSigned = 1, SNG SHALL give: res[31] = 1, res[32] = 0, res[30:23] = 8'hff, frac = 0 (-1.0).
REQ-032 Converting A = 64'h0020_0000_0000_0001 (2^53 + 1), DBL SHALL round to even, giving E = 12'h7ff + 53 and frac = 0, with inexact = 1.
REQ-033 Converting A = 64'hFFFF_FFFF_FFFF_FFFF, unsigned, SNG SHALL round up to 2^64, giving E = 9'h13f and frac = 0, with inexact = 1.
REQ-034 Back-to-back operands with clkEn low for 2 cycles mid-stream SHALL produce results in order, with latency extended by exactly 2 cycles.
REQ-035 rst = 0 asserted while 2 operands are in flight SHALL produce no res_vld pulses for those operands.
